// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default widths, register bit ordinals
// and the parity helper used by the transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DIV_WIDTH  = 16;
    localparam int MAX_DATA_WIDTH     = 9;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    // CTRL register bit ordinals
    localparam int CTRL_START   = 0;
    localparam int CTRL_PAR_EN  = 1;
    localparam int CTRL_PAR_ODD = 2;
    localparam int CTRL_STOP2   = 3;

    // STATUS register bit ordinals
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_TX_DONE = 1;

    // Even parity is the XOR of the payload; odd parity is its complement.
    // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div_i and emits a one-cycle tick on the last
// count of each period. Shared between the UART transmitter and receiver.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 bit_tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 at_end;

    assign at_end     = (cnt_q == div_i);
    assign bit_tick_o = enable_i && !clear_i && at_end;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_end ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a start request from the control register, serialises
// start/data/parity/stop bits LSB first and reports acceptance and completion.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  stop2_i,
    output logic                  ready_o,
    output logic                  start_clr_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  tx_o
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q,      state_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic                  stop_cnt_q,   stop_cnt_d;
    logic [DIV_WIDTH-1:0]  baud_div_q,   baud_div_d;
    logic                  parity_en_q,  parity_en_d;
    logic                  parity_bit_q, parity_bit_d;
    logic                  stop2_q,      stop2_d;
    logic                  tx_q,         tx_d;
    logic                  done_q,       done_d;

    logic                  accept;
    logic                  bit_tick;
    logic                  in_idle;

    assign in_idle = (state_q == S_IDLE);

    // Counter is held at zero in IDLE so the first start-bit cycle begins a full period.
    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (in_idle),
        .enable_i   (!in_idle),
        .div_i      (baud_div_q),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        baud_div_d   = baud_div_q;
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
        stop2_d      = stop2_q;
        done_d       = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept       = 1'b1;
                    shift_d      = data_i;
                    baud_div_d   = baud_div_i;
                    parity_en_d  = parity_en_i;
                    parity_bit_d = calc_parity(MAX_DATA_WIDTH'(data_i), parity_odd_i);
                    stop2_d      = stop2_i;
                    bit_cnt_d    = '0;
                    stop_cnt_d   = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = parity_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The line level is a function of the state being entered, so tx_o is
        // registered yet aligned with the state it belongs to.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            baud_div_q   <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop2_q      <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            baud_div_q   <= baud_div_d;
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
            stop2_q      <= stop2_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign ready_o     = in_idle;
    assign busy_o      = !in_idle;
    assign start_clr_o = accept;
    assign done_o      = done_q;
    assign tx_o        = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels are queued per clock when
// a frame is requested and compared cycle by cycle as the DUT shifts them out.
module tb_uart_tx;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b1;
    logic        start_i      = 1'b0;
    logic [7:0]  data_i       = '0;
    logic [15:0] baud_div_i   = '0;
    logic        parity_en_i  = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        stop2_i      = 1'b0;
    logic        ready_o, start_clr_o, done_o, busy_o, tx_o;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    uart_tx #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .data_i       (data_i),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .ready_o      (ready_o),
        .start_clr_o  (start_clr_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .tx_o         (tx_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one queue entry per clock of the expected line level.
    task automatic push_frame(input logic [7:0] d, input int div, input bit pen,
                              input bit podd, input bit s2);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(podd ? ~(^d) : (^d));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k <= div; k++) exp_q.push_back(bits[i]);
        end
    endtask

    task automatic drive_cfg(input logic [7:0] d, input logic [15:0] div, input bit pen,
                             input bit podd, input bit s2);
        data_i       = d;
        baud_div_i   = div;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({tx_o, ready_o, busy_o, start_clr_o, done_o} !== 5'b11000)
            $display("FAIL reset_state: got %b expected 11000",
                     {tx_o, ready_o, busy_o, start_clr_o, done_o});
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            checks++;
            if ({tx_o, ready_o, busy_o, start_clr_o, done_o} !== 5'b11000) begin
                failures++;
                $display("FAIL idle_cycle_%0d: got %b expected 11000", i,
                         {tx_o, ready_o, busy_o, start_clr_o, done_o});
            end
        end
    endtask

    task automatic test_frames();
        logic [7:0]  t_data [4] = '{8'hA5, 8'h03, 8'h03, 8'h96};
        logic [15:0] t_div  [4] = '{16'd3, 16'd0, 16'd0, 16'd2};
        bit          t_pen  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bit          t_podd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit          t_s2   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 4; f++) begin
            @(negedge clk_i);
            drive_cfg(t_data[f], t_div[f], t_pen[f], t_podd[f], t_s2[f]);
            start_i = 1'b1;
            push_frame(t_data[f], int'(t_div[f]), t_pen[f], t_podd[f], t_s2[f]);
            #1;
            checks++;
            if (start_clr_o !== 1'b1 || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL frame%0d_accept: start_clr=%b ready=%b expected 1 1",
                         f, start_clr_o, ready_o);
            end
            @(negedge clk_i);
            start_i = 1'b0;
            drive_cfg(~t_data[f], 16'd7, ~t_pen[f], ~t_podd[f], ~t_s2[f]);
            #1;
            checks++;
            if (start_clr_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL frame%0d_after_accept: start_clr=%b busy=%b expected 0 1",
                         f, start_clr_o, busy_o);
            end
            for (int n = 0; exp_q.size() > 0; n++) begin
                bit e = exp_q.pop_front();
                checks++;
                if (tx_o !== e || done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL frame%0d_clk%0d: tx=%b done=%b expected tx=%b done=0",
                             f, n, tx_o, done_o, e);
                end
                @(negedge clk_i);
            end
            checks++;
            if ({done_o, ready_o, tx_o} !== 3'b111) begin
                failures++;
                $display("FAIL frame%0d_done: done,ready,tx=%b expected 111", f,
                         {done_o, ready_o, tx_o});
            end
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_done_width: done=%b expected 0", f, done_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        drive_cfg(8'hC3, 16'd1, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;
        push_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int n = 0; exp_q.size() > 0; n++) begin
            bit e = exp_q.pop_front();
            checks++;
            if (tx_o !== e) begin
                failures++;
                $display("FAIL b2b_a_clk%0d: tx=%b expected %b", n, tx_o, e);
            end
            if (n == 6) data_i = 8'h5A;
            if (exp_q.size() < 3) begin
                start_i = 1'b1;
                #1;
                checks++;
                if (start_clr_o !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_reissue_clk%0d: start_clr=%b expected 0", n, start_clr_o);
                end
            end
            @(negedge clk_i);
        end
        checks++;
        if ({done_o, start_clr_o, tx_o} !== 3'b111) begin
            failures++;
            $display("FAIL b2b_reaccept: done,start_clr,tx=%b expected 111",
                     {done_o, start_clr_o, tx_o});
        end
        push_frame(8'h5A, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        checks++;
        if (start_clr_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_held_start: start_clr=%b expected 0", start_clr_o);
        end
        start_i = 1'b0;
        for (int n = 0; exp_q.size() > 0; n++) begin
            bit e = exp_q.pop_front();
            checks++;
            if (tx_o !== e) begin
                failures++;
                $display("FAIL b2b_b_clk%0d: tx=%b expected %b", n, tx_o, e);
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_b_done: done=%b expected 1", done_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk_i);
        drive_cfg(8'h0F, 16'd3, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;
        push_frame(8'h0F, 3, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int n = 0; n < 22; n++) begin
            bit e = exp_q.pop_front();
            checks++;
            if (tx_o !== e) begin
                failures++;
                $display("FAIL rst_frame_clk%0d: tx=%b expected %b", n, tx_o, e);
            end
            @(negedge clk_i);
        end
        exp_q.delete();
        checks++;
        if (tx_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_bit4: tx=%b expected 0", tx_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({tx_o, ready_o, busy_o} !== 3'b110) begin
            failures++;
            $display("FAIL rst_async: tx,ready,busy=%b expected 110", {tx_o, ready_o, busy_o});
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || tx_o !== 1'b1) begin
                failures++;
                $display("FAIL rst_no_done_%0d: done=%b tx=%b expected 0 1", i, done_o, tx_o);
            end
        end
        drive_cfg(8'hFF, 16'd2, 1'b1, 1'b0, 1'b1);
        start_i = 1'b1;
        push_frame(8'hFF, 2, 1'b1, 1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int n = 0; exp_q.size() > 0; n++) begin
            bit e = exp_q.pop_front();
            checks++;
            if (tx_o !== e) begin
                failures++;
                $display("FAIL post_rst_clk%0d: tx=%b expected %b", n, tx_o, e);
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_done: done=%b expected 1", done_o);
        end
    endtask

    task automatic test_max_div();
        int n = 0;
        @(negedge clk_i);
        drive_cfg(8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (tx_o === 1'b0 && n < 70000) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n !== 65536) begin
            failures++;
            $display("FAIL max_div_start_bit: held %0d clocks expected 65536", n);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_max_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
